// File: rtl/legv8_core_fde_pkg.sv
// Shared LEGv8 definitions: widths, opcode constants, ALU/immediate enums,
// flag bit positions and the instruction decoder.
package legv8_core_fde_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_ORR,
    ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_D,
    IMM_CB,
    IMM_B
  } imm_kind_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      flag_write;
    logic      use_imm;
    logic      rm_is_rt;
    logic      branch;
    logic      cbz;
    logic      cbnz;
    alu_op_e   alu_op;
    imm_kind_e imm_kind;
  } ctrl_t;

  // Unrecognised encodings fall through with every enable low, i.e. a NOP.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    c.alu_op   = ALU_ADD;
    c.imm_kind = IMM_NONE;
    if (instr[31:21] == OP_ADD) begin
      c.reg_write = 1'b1;
    end else if (instr[31:21] == OP_SUB) begin
      c.reg_write = 1'b1;
      c.alu_op    = ALU_SUB;
    end else if (instr[31:21] == OP_AND) begin
      c.reg_write = 1'b1;
      c.alu_op    = ALU_AND;
    end else if (instr[31:21] == OP_ORR) begin
      c.reg_write = 1'b1;
      c.alu_op    = ALU_ORR;
    end else if (instr[31:21] == OP_ADDS) begin
      c.reg_write  = 1'b1;
      c.flag_write = 1'b1;
    end else if (instr[31:21] == OP_SUBS) begin
      c.reg_write  = 1'b1;
      c.flag_write = 1'b1;
      c.alu_op     = ALU_SUB;
    end else if (instr[31:21] == OP_LDUR) begin
      c.reg_write = 1'b1;
      c.mem_read  = 1'b1;
      c.use_imm   = 1'b1;
      c.imm_kind  = IMM_D;
    end else if (instr[31:21] == OP_STUR) begin
      c.mem_write = 1'b1;
      c.use_imm   = 1'b1;
      c.rm_is_rt  = 1'b1;
      c.imm_kind  = IMM_D;
    end else if (instr[31:22] == OP_ADDI) begin
      c.reg_write = 1'b1;
      c.use_imm   = 1'b1;
      c.imm_kind  = IMM_I;
    end else if (instr[31:22] == OP_SUBI) begin
      c.reg_write = 1'b1;
      c.use_imm   = 1'b1;
      c.alu_op    = ALU_SUB;
      c.imm_kind  = IMM_I;
    end else if (instr[31:26] == OP_B) begin
      c.branch   = 1'b1;
      c.imm_kind = IMM_B;
    end else if (instr[31:24] == OP_CBZ) begin
      c.cbz      = 1'b1;
      c.rm_is_rt = 1'b1;
      c.alu_op   = ALU_PASSB;
      c.imm_kind = IMM_CB;
    end else if (instr[31:24] == OP_CBNZ) begin
      c.cbnz     = 1'b1;
      c.rm_is_rt = 1'b1;
      c.alu_op   = ALU_PASSB;
      c.imm_kind = IMM_CB;
    end
    return c;
  endfunction

endpackage

// File: rtl/legv8_regfile.sv
// 32-entry register file: two combinational read ports, one write port.
// X31 reads as zero and ignores writes; a same-cycle read sees the old value.
module legv8_regfile #(
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [4:0]        i_rn_addr,
  input  logic [4:0]        i_rm_addr,
  input  logic              i_we,
  input  logic [4:0]        i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rn_data,
  output logic [DATA_W-1:0] o_rm_data
);

  logic [DATA_W-1:0] r_regs [32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wr_addr != 5'd31)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rn_data = (i_rn_addr == 5'd31) ? '0 : r_regs[i_rn_addr];
  assign o_rm_data = (i_rm_addr == 5'd31) ? '0 : r_regs[i_rm_addr];

endmodule

// File: rtl/legv8_core_fde.sv
// Single-cycle LEGv8 subset core: fetch, decode, execute and write-back of one
// instruction per clock, with combinational instruction and data memories.
module legv8_core_fde #(
  parameter int WORD      = legv8_core_fde_pkg::WORD,
  parameter int INSTR_LEN = legv8_core_fde_pkg::INSTR_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WORD-1:0]      imem_addr,
  input  logic [INSTR_LEN-1:0] imem_data,
  output logic [WORD-1:0]      dmem_addr,
  output logic [WORD-1:0]      dmem_wdata,
  output logic                 dmem_read,
  output logic                 dmem_write,
  input  logic [WORD-1:0]      dmem_rdata,
  output logic [WORD-1:0]      pc,
  output logic [3:0]           flags
);
  import legv8_core_fde_pkg::ctrl_t;
  import legv8_core_fde_pkg::decode;
  import legv8_core_fde_pkg::ALU_ADD;
  import legv8_core_fde_pkg::ALU_SUB;
  import legv8_core_fde_pkg::ALU_AND;
  import legv8_core_fde_pkg::ALU_ORR;
  import legv8_core_fde_pkg::ALU_PASSB;
  import legv8_core_fde_pkg::IMM_NONE;
  import legv8_core_fde_pkg::IMM_I;
  import legv8_core_fde_pkg::IMM_D;
  import legv8_core_fde_pkg::IMM_CB;
  import legv8_core_fde_pkg::IMM_B;
  import legv8_core_fde_pkg::FLAG_N;
  import legv8_core_fde_pkg::FLAG_Z;
  import legv8_core_fde_pkg::FLAG_C;
  import legv8_core_fde_pkg::FLAG_V;

  logic [WORD-1:0] r_pc;
  logic [3:0]      r_flags;

  logic [31:0]     w_instr;
  ctrl_t           w_ctrl;
  logic [WORD-1:0] w_imm;
  logic [WORD-1:0] w_rn_data;
  logic [WORD-1:0] w_rm_data;
  logic [4:0]      w_rm_addr;
  logic [WORD-1:0] w_alu_b;
  logic [WORD-1:0] w_b_eff;
  logic [WORD:0]   w_sum;
  logic [WORD-1:0] w_alu_res;
  logic [3:0]      w_alu_flags;
  logic [WORD-1:0] w_wb_data;
  logic [WORD-1:0] w_pc_plus4;
  logic [WORD-1:0] w_target;
  logic            w_take;
  logic [WORD-1:0] w_next_pc;

  // ---------------- decode ----------------
  assign w_instr   = imem_data[31:0];
  assign w_ctrl    = decode(w_instr);
  assign w_rm_addr = w_ctrl.rm_is_rt ? w_instr[4:0] : w_instr[20:16];

  always_comb begin
    w_imm = '0;
    case (w_ctrl.imm_kind)
      IMM_I:    w_imm = {{(WORD-12){1'b0}}, w_instr[21:10]};
      IMM_D:    w_imm = {{(WORD-9){w_instr[20]}}, w_instr[20:12]};
      IMM_CB:   w_imm = {{(WORD-19){w_instr[23]}}, w_instr[23:5]};
      IMM_B:    w_imm = {{(WORD-26){w_instr[25]}}, w_instr[25:0]};
      IMM_NONE: w_imm = '0;
      default:  w_imm = '0;
    endcase
  end

  legv8_regfile #(.DATA_W(WORD)) u_regfile (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_rn_addr (w_instr[9:5]),
    .i_rm_addr (w_rm_addr),
    .i_we      (w_ctrl.reg_write),
    .i_wr_addr (w_instr[4:0]),
    .i_wr_data (w_wb_data),
    .o_rn_data (w_rn_data),
    .o_rm_data (w_rm_data)
  );

  // ---------------- execute ----------------
  // Subtraction is A + ~B + 1, so the carry-out is the "no borrow" flag.
  assign w_alu_b = w_ctrl.use_imm ? w_imm : w_rm_data;
  assign w_b_eff = (w_ctrl.alu_op == ALU_SUB) ? ~w_alu_b : w_alu_b;
  assign w_sum   = {1'b0, w_rn_data} + {1'b0, w_b_eff}
                 + {{WORD{1'b0}}, (w_ctrl.alu_op == ALU_SUB)};

  always_comb begin
    w_alu_res = w_sum[WORD-1:0];
    case (w_ctrl.alu_op)
      ALU_ADD, ALU_SUB: w_alu_res = w_sum[WORD-1:0];
      ALU_AND:          w_alu_res = w_rn_data & w_alu_b;
      ALU_ORR:          w_alu_res = w_rn_data | w_alu_b;
      ALU_PASSB:        w_alu_res = w_alu_b;
      default:          w_alu_res = w_sum[WORD-1:0];
    endcase
  end

  always_comb begin
    w_alu_flags         = 4'b0000;
    w_alu_flags[FLAG_N] = w_alu_res[WORD-1];
    w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    w_alu_flags[FLAG_C] = w_sum[WORD];
    w_alu_flags[FLAG_V] = (w_rn_data[WORD-1] == w_b_eff[WORD-1]) &&
                          (w_alu_res[WORD-1] != w_rn_data[WORD-1]);
  end

  assign w_wb_data = w_ctrl.mem_read ? dmem_rdata : w_alu_res;

  // ---------------- fetch / next PC ----------------
  assign w_pc_plus4 = r_pc + WORD'(4);
  assign w_target   = r_pc + (w_imm << 2);
  assign w_take     = w_ctrl.branch
                    | (w_ctrl.cbz  & (w_alu_res == '0))
                    | (w_ctrl.cbnz & (w_alu_res != '0));
  assign w_next_pc  = w_take ? w_target : w_pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_flags <= 4'b0000;
    end else begin
      r_pc <= w_next_pc;
      if (w_ctrl.flag_write) r_flags <= w_alu_flags;
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign flags      = r_flags;
  assign dmem_addr  = w_alu_res;
  assign dmem_wdata = w_rm_data;
  assign dmem_read  = w_ctrl.mem_read  & ~reset;
  assign dmem_write = w_ctrl.mem_write & ~reset;

endmodule

// File: tb/tb_legv8_core_fde.sv
// Bench for legv8_core_fde: directed program checks plus a randomized program
// compared each cycle against an instruction-level reference model.
module tb_legv8_core_fde;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [63:0] dmem_rdata;
  logic [63:0] pc;
  logic [3:0]  flags;

  localparam logic [31:0] NOP = 32'hD503201F;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [63:0] env_mem [64];
  logic        clr_mem = 1'b0;

  assign imem_data  = imem[imem_addr[7:2]];
  assign dmem_rdata = env_mem[dmem_addr[8:3]];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= 64'd0;
    end else if (dmem_write) begin
      env_mem[dmem_addr[8:3]] <= dmem_wdata;
    end
  end

  legv8_core_fde dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .flags      (flags)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_reg(input int i);
    return dut.u_regfile.r_regs[i];
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'b000000, rn, rd};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] off,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, off, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                         input logic [4:0] rt);
    return {op, imm, rt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic clear_mem);
    @(negedge clk);
    reset   = 1'b1;
    clr_mem = clear_mem;
    @(posedge clk);
    @(negedge clk);
    clr_mem = 1'b0;
    reset   = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_regs [32];
  logic [63:0] m_mem [64];
  logic [63:0] m_pc;
  logic [3:0]  m_flags;
  logic        e_rd, e_wr, wb_en;
  logic [63:0] e_addr, e_wdata, wb_val, n_pc;
  logic [4:0]  wb_idx;
  logic [3:0]  n_flags;

  function automatic logic [63:0] rv(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_regs[i];
  endfunction

  task automatic model_reset();
    m_pc    = 64'd0;
    m_flags = 4'b0000;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
  endtask

  task automatic model_eval();
    logic [31:0]        ins;
    logic [63:0]        a, b, r;
    logic [64:0]        w;
    logic signed [64:0] sd;
    longint             off;
    ins = imem[m_pc[7:2]];
    a = rv(ins[9:5]);
    b = rv(ins[20:16]);
    e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
    wb_en = 0; wb_idx = ins[4:0]; wb_val = 0;
    n_flags = m_flags;
    n_pc = m_pc + 64'd4;
    case (ins[31:21])
      11'b10001011000: begin wb_en = 1; wb_val = a + b; end
      11'b11001011000: begin wb_en = 1; wb_val = a - b; end
      11'b10001010000: begin wb_en = 1; wb_val = a & b; end
      11'b10101010000: begin wb_en = 1; wb_val = a | b; end
      11'b10101011000: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[63:0];
        sd = $signed({a[63], a}) + $signed({b[63], b});
        n_flags = {r[63], (r == 64'd0), w[64], (sd[64] != sd[63])};
        wb_en = 1; wb_val = r;
      end
      11'b11101011000: begin
        r  = a - b;
        sd = $signed({a[63], a}) - $signed({b[63], b});
        n_flags = {r[63], (r == 64'd0), (a >= b), (sd[64] != sd[63])};
        wb_en = 1; wb_val = r;
      end
      11'b11111000010: begin
        off = $signed(ins[20:12]);
        e_addr = a + 64'(off);
        e_rd = 1; wb_en = 1; wb_val = m_mem[e_addr[8:3]];
      end
      11'b11111000000: begin
        off = $signed(ins[20:12]);
        e_addr = a + 64'(off);
        e_wr = 1; e_wdata = rv(ins[4:0]);
      end
      default: begin
        if (ins[31:22] == 10'b1001000100) begin
          wb_en = 1; wb_val = a + {52'd0, ins[21:10]};
        end else if (ins[31:22] == 10'b1101000100) begin
          wb_en = 1; wb_val = a - {52'd0, ins[21:10]};
        end else if (ins[31:26] == 6'b000101) begin
          off = $signed(ins[25:0]);
          n_pc = m_pc + 64'(off * 4);
        end else if (ins[31:24] == 8'b10110100) begin
          off = $signed(ins[23:5]);
          if (rv(ins[4:0]) == 64'd0) n_pc = m_pc + 64'(off * 4);
        end else if (ins[31:24] == 8'b10110101) begin
          off = $signed(ins[23:5]);
          if (rv(ins[4:0]) != 64'd0) n_pc = m_pc + 64'(off * 4);
        end
      end
    endcase
  endtask

  task automatic model_commit();
    m_pc    = n_pc;
    m_flags = n_flags;
    if (wb_en && wb_idx != 5'd31) m_regs[wb_idx] = wb_val;
    if (e_wr) m_mem[e_addr[8:3]] = e_wdata;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_pc"}, pc, m_pc);
    check_val({tag, "_flags"}, {60'd0, flags}, {60'd0, m_flags});
    for (int i = 0; i < 32; i++)
      check_val($sformatf("%s_x%0d", tag, i), dut_reg(i), (i == 31) ? 64'd0 : m_regs[i]);
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    int k;
    logic [31:0] v;
    k = $urandom_range(-8, 8);
    case ($urandom_range(0, 13))
      0:  return enc_r(11'b10001011000, rand_reg(), rand_reg(), rand_reg());
      1:  return enc_r(11'b11001011000, rand_reg(), rand_reg(), rand_reg());
      2:  return enc_r(11'b10001010000, rand_reg(), rand_reg(), rand_reg());
      3:  return enc_r(11'b10101010000, rand_reg(), rand_reg(), rand_reg());
      4:  return enc_r(11'b10101011000, rand_reg(), rand_reg(), rand_reg());
      5:  return enc_r(11'b11101011000, rand_reg(), rand_reg(), rand_reg());
      6:  return enc_i(10'b1001000100, 12'($urandom), rand_reg(), rand_reg());
      7:  return enc_i(10'b1101000100, 12'($urandom), rand_reg(), rand_reg());
      8:  return enc_d(11'b11111000010, 9'($urandom), rand_reg(), rand_reg());
      9:  return enc_d(11'b11111000000, 9'($urandom), rand_reg(), rand_reg());
      10: return enc_b(26'(k));
      11: return enc_cb(8'b10110100, 19'(k), rand_reg());
      12: return enc_cb(8'b10110101, 19'(k), rand_reg());
      default: begin
        v = $urandom;
        return v;
      end
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] br_ins [3];
  logic [63:0] br_exp [3];

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOP;

    // Reset values and NOP stream.
    do_reset(1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_pc", pc, 64'd0);
    check_val("rst_flags", {60'd0, flags}, 64'd0);
    check_val("rst_dmem_write", {63'd0, dmem_write}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("nop_pc0", pc, 64'd0);
    step(); check_val("nop_pc4", pc, 64'd4);
    step(); check_val("nop_pc8", pc, 64'd8);
    check_val("nop_flags", {60'd0, flags}, 64'd0);

    // Directed arithmetic / memory / X31 program.
    imem[0]  = enc_i(10'b1001000100, 12'd5, 5'd31, 5'd1);
    imem[1]  = enc_i(10'b1001000100, 12'd3, 5'd31, 5'd2);
    imem[2]  = enc_r(11'b11101011000, 5'd2, 5'd1, 5'd3);
    imem[3]  = enc_r(11'b11101011000, 5'd1, 5'd2, 5'd4);
    imem[4]  = enc_d(11'b11111000000, 9'd16, 5'd31, 5'd1);
    imem[5]  = enc_d(11'b11111000010, 9'd16, 5'd31, 5'd5);
    imem[6]  = enc_i(10'b1001000100, 12'd9, 5'd31, 5'd6);
    imem[7]  = enc_i(10'b1001000100, 12'd7, 5'd31, 5'd31);
    imem[8]  = enc_r(11'b10001011000, 5'd31, 5'd31, 5'd6);
    imem[9]  = enc_i(10'b1001000100, 12'd1, 5'd31, 5'd7);
    do_reset(1'b1);
    #1;
    step(); check_val("addi_x1", dut_reg(1), 64'd5);
    step(); check_val("addi_x2", dut_reg(2), 64'd3);
    step(); check_val("subs_x3", dut_reg(3), 64'd2);
    check_val("subs_flags_pos", {60'd0, flags}, 64'b0010);
    step(); check_val("subs_x4", dut_reg(4), 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("subs_flags_neg", {60'd0, flags}, 64'b1000);
    check_val("stur_write", {63'd0, dmem_write}, 64'd1);
    check_val("stur_read", {63'd0, dmem_read}, 64'd0);
    check_val("stur_addr", dmem_addr, 64'd16);
    check_val("stur_wdata", dmem_wdata, 64'd5);
    step();
    check_val("ldur_read", {63'd0, dmem_read}, 64'd1);
    check_val("ldur_write", {63'd0, dmem_write}, 64'd0);
    check_val("ldur_addr", dmem_addr, 64'd16);
    step(); check_val("ldur_x5", dut_reg(5), 64'd5);
    step(); check_val("addi_x6", dut_reg(6), 64'd9);
    step(); check_val("x31_discard", dut_reg(31), 64'd0);
    step(); check_val("add_x31_x6", dut_reg(6), 64'd0);
    check_val("seq_pc", pc, 64'h24);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_pc", pc, 64'd0);
    check_val("midrst_x1", dut_reg(1), 64'd0);
    check_val("midrst_x4", dut_reg(4), 64'd0);
    check_val("midrst_flags", {60'd0, flags}, 64'd0);
    check_val("midrst_dmem_write", {63'd0, dmem_write}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("after_rst_pc", pc, 64'd0);
    step(); check_val("after_rst_pc4", pc, 64'd4);
    check_val("after_rst_x1", dut_reg(1), 64'd5);

    // Branches placed at 0x20 behind a run of NOPs.
    br_ins[0] = enc_cb(8'b10110100, 19'h7FFFE, 5'd31); br_exp[0] = 64'h18;
    br_ins[1] = enc_cb(8'b10110101, 19'h7FFFE, 5'd31); br_exp[1] = 64'h24;
    br_ins[2] = enc_b(26'd3);                         br_exp[2] = 64'h2C;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) imem[i] = NOP;
      imem[8] = br_ins[t];
      do_reset(1'b0);
      #1;
      for (int s = 0; s < 8; s++) step();
      check_val($sformatf("br%0d_at", t), pc, 64'h20);
      step();
      check_val($sformatf("br%0d_next", t), pc, br_exp[t]);
    end

    // Randomized program against the reference model.
    for (int i = 0; i < 64; i++) begin
      imem[i]  = rand_instr();
      m_mem[i] = 64'd0;
    end
    do_reset(1'b1);
    model_reset();
    #1;
    check_state("rnd_start");
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state("rnd_rst");
        check_val("rnd_rst_dmem_write", {63'd0, dmem_write}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
      end
      model_eval();
      check_val("rnd_dmem_read", {63'd0, dmem_read}, {63'd0, e_rd});
      check_val("rnd_dmem_write", {63'd0, dmem_write}, {63'd0, e_wr});
      if (e_rd || e_wr) check_val("rnd_dmem_addr", dmem_addr, e_addr);
      if (e_wr) check_val("rnd_dmem_wdata", dmem_wdata, e_wdata);
      model_commit();
      step();
      check_state($sformatf("rnd_c%0d", cyc));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
